// File: rtl/tile_arb_pkg.sv
// Shared types and default sizing for the tile ROM arbiter and its round-robin picker.
package tile_arb_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int ADDR_W_DEF    = 10;
    localparam int DATA_W_DEF    = 4;
    localparam int ROM_LAT_DEF   = 1;
    localparam int MAX_BURST_DEF = 32;
    localparam int NUM_REQ_MAX   = 8;
    localparam int ID_W          = $clog2(NUM_REQ_MAX);

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } arb_tag_t;

    // Wraps at n, not at 2^ID_W, so odd requester counts rotate correctly.
    function automatic req_id_t next_id(input req_id_t cur, input int n);
        return (int'(cur) == n - 1) ? '0 : cur + 1'b1;
    endfunction

endpackage

// File: rtl/tile_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping at NUM_REQ.
module tile_arb_rr_pick
    import tile_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  req_id_t            ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output req_id_t            id_o,
    output logic               any_o
);

    always_comb begin
        int                 idx;
        logic [NUM_REQ-1:0] sel;
        gnt_o = '0;
        id_o  = '0;
        any_o = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = NUM_REQ'(1) << idx;
            if (!any_o && (|(req_i & sel))) begin
                gnt_o = sel;
                id_o  = req_id_t'(idx);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_rom_arbiter.sv
// Round-robin sharing of one tile/sprite ROM read port, with tagged responses ROM_LAT+1 cycles
// after grant. Optional burst lock compiled in with the TILE_ARB_LOCK_EN macro.
module tile_rom_arbiter
    import tile_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ROM_LAT   = ROM_LAT_DEF
`ifdef TILE_ARB_LOCK_EN
    ,
    parameter int MAX_BURST = MAX_BURST_DEF
`endif
) (
    input  logic                      vga_clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data
`ifdef TILE_ARB_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0]        req_lock
`endif
);

    // Handshake: req is a level; a cycle with gnt[i] high is one accepted read of req_addr[i],
    // answered by exactly one rsp_valid[i] pulse. An ungranted req is not remembered.

    logic [NUM_REQ-1:0] rr_gnt;
    req_id_t            rr_id;
    logic               rr_any;

    logic [NUM_REQ-1:0] win_gnt;
    req_id_t            win_id;
    logic               win_any;
    logic               locked;

    req_id_t            ptr_q, ptr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    arb_tag_t           tag_q [ROM_LAT];
    arb_tag_t           out_tag;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    tile_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .id_o  (rr_id),
        .any_o (rr_any)
    );

`ifdef TILE_ARB_LOCK_EN
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    // burst_q counts consecutive grants to last_gnt_q in the current burst, the first included.
    logic [NUM_REQ-1:0] last_gnt_q;
    req_id_t            last_id_q;
    logic [BURST_W-1:0] burst_q, burst_d;

    always_comb begin
        locked = (|(last_gnt_q & req & req_lock)) && (burst_q < BURST_W'(MAX_BURST));
        if (locked) begin
            burst_d = burst_q + 1'b1;
        end else if (rr_any) begin
            burst_d = BURST_W'(1);
        end else begin
            burst_d = '0;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            last_gnt_q <= '0;
            last_id_q  <= '0;
            burst_q    <= '0;
        end else begin
            last_gnt_q <= win_gnt;
            last_id_q  <= win_id;
            burst_q    <= burst_d;
        end
    end
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        win_gnt = rr_gnt;
        win_id  = rr_id;
        win_any = rr_any;
`ifdef TILE_ARB_LOCK_EN
        if (locked) begin
            win_gnt = last_gnt_q;
            win_id  = last_id_q;
            win_any = 1'b1;
        end
`endif
        ptr_d  = ptr_q;
        addr_d = addr_q;
        if (win_any) begin
            addr_d = req_addr[int'(win_id)*ADDR_W +: ADDR_W];
            if (!locked) begin
                ptr_d = next_id(win_id, NUM_REQ);
            end
        end
    end

    assign gnt = reset ? '0 : win_gnt;

    // The last tag stage lines up with rom_q being valid for that grant's address.
    always_comb begin
        out_tag     = tag_q[ROM_LAT-1];
        rsp_valid_d = out_tag.valid ? (NUM_REQ'(1) << out_tag.id) : '0;
        rsp_data_d  = out_tag.valid ? rom_q : rsp_data_q;
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            addr_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            for (int s = 0; s < ROM_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            tag_q[0]    <= {win_any, win_id};
            for (int s = 1; s < ROM_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign rom_address = addr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;

endmodule

// File: doc/tile_rom_arbiter.md
# tile_rom_arbiter

Shares a single tile/sprite ROM read port among several pixel requesters (playfield, tank sprites, projectiles) in the VGA pixel clock domain. Grants one requester per cycle by round-robin, drives the ROM address, and returns the 4-bit palette index to the granted requester, tagged by requester, after a fixed latency. Sits between the per-object draw logic and the `<name>_rom` instance, ahead of the palette lookup.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 10, ROM address width
- DATA_W, 4, ROM word width (palette index)
- ROM_LAT, 1, posedge cycles from `rom_address` valid to `rom_q` valid (negedge-clocked ROM gives 1)
- MAX_BURST, 32, max consecutive locked grants (only with the lock feature)

- vga_clk  in  1  pixel clock; all state on posedge
- reset  in  1  asynchronous, active-high
- req  in  NUM_REQ  per-requester read request, level
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_REQ  one-hot (or zero) grant, combinational, same cycle as `req`
- rom_address  out  ADDR_W  registered ROM address
- rom_q  in  DATA_W  ROM read data
- rsp_valid  out  NUM_REQ  one-hot response strobe, registered
- rsp_data  out  DATA_W  response word, registered
- req_lock  in  NUM_REQ  burst lock (only with TILE_ARB_LOCK_EN)

## Operation
- Round-robin pointer `ptr` (0..NUM_REQ-1): search starts at `ptr`, wraps; first requester with `req` set is granted.
- Grant to i in a cycle: `ptr` <= (i+1) mod NUM_REQ; `rom_address` <= req_addr[i]; tag {valid=1, id=i} enters the tag pipeline.
- No request: `gnt`=0, `ptr` and `rom_address` hold, bubble tag (valid=0) enters pipeline.
- Tag pipeline depth 1+ROM_LAT; output stage sets `rsp_valid[id]` = tag.valid and `rsp_data` <= `rom_q`. `rsp_data` holds its last value when no response is issued.
- Requester may change `req_addr` every cycle; each accepted cycle is one independent read. A request not granted must stay asserted; it is not queued.
- Arithmetic: `ptr` increment wraps at NUM_REQ (not 2^n); NUM_REQ non-power-of-two supported.
- Reset (any time, including mid-stream): `ptr`=0, `rom_address`=0, `rsp_valid`=0, `rsp_data`=0, all tags invalid, lock counter 0; `gnt` forced 0 while reset high. In-flight reads are dropped, never returned.

## Timing
- Request seen and granted in cycle N; `rom_address` valid in N+1; `rsp_valid`/`rsp_data` valid in cycle N+1+ROM_LAT (N+2 at default).
- Full throughput: one grant per cycle, back-to-back, any mix of requesters.
- All requesters asserted continuously: grants rotate 0,1,2,3,0,... each requester served once per NUM_REQ cycles.
- Single requester asserted continuously: granted every cycle.

## Configuration
- TILE_ARB_LOCK_EN defined: `req_lock` port exists. If the currently granted requester holds `req` and `req_lock` in the next cycle, it is granted again and `ptr` is not advanced; a counter counts consecutive locked grants. After MAX_BURST consecutive grants the lock is ignored for one arbitration, `ptr` advances normally, counter clears. Dropping `req` or `req_lock` releases immediately and clears the counter.
- Not defined: no `req_lock` port, no counter; pure per-cycle round-robin, MAX_BURST unused.

## Structure
- Package `tile_arb_pkg`: default NUM_REQ/ADDR_W/DATA_W constants, `req_id_t` (clog2 of max NUM_REQ), `arb_tag_t` struct {valid, id}.
- Sub-module `tile_arb_rr_pick`: combinational round-robin picker (req vector + ptr in, one-hot gnt + id + any_gnt out). Everything else (pointer, address register, tag pipeline, lock counter) in the top.

## Test plan
- Reset then req=4'b0001, req_addr[0]=10'h155 in cycle 0 -> gnt=0001 in cycle 0, rom_address=10'h155 in cycle 1, rsp_valid=0001 with rsp_data=ROM[0x155] in cycle 2.
- req=4'b1111 held 8 cycles, distinct addresses -> gnt sequence 0,1,2,3,0,1,2,3; responses in same order, 2 cycles later, correct data each.
- req=4'b1010 with ptr=0 -> grants 1,3,1,3; requesters 0 and 2 never granted; no response lost.
- Assert reset in the cycle after two grants -> no rsp_valid for those reads, all outputs 0, first grant after release goes to lowest-index requester.
- NUM_REQ=3, all requesting -> pointer wraps 2->0, grant order 0,1,2,0.
- TILE_ARB_LOCK_EN, requester 2 holds req+lock, requester 0 also requests -> 32 consecutive grants to 2, then one grant to 0, then lock resumes for 2.
